// File: rtl/lin_buff_ctrl.sv
// lin_buff_ctrl
// Frame sequencer between the line-buffer kernel output and the HOG gradient
// stage. It arms one frame per start, forwards interior windows tagged with
// their top-left position and frame markers, drops row-wrap border windows,
// and then swallows the windows that straddle two frames before going idle.
module lin_buff_ctrl #(
   parameter int IMG_WIDTH    = 854,
   parameter int IMG_HEIGHT   = 480,
   parameter int BLOCK_WIDTH  = 3,
   parameter int BLOCK_HEIGHT = 3,
   parameter int COL_WIDTH    = 10,
   parameter int ROW_WIDTH    = 9
) (
   input  logic                 clk,
   input  logic                 rst,         // active-low, asynchronous
   input  logic                 start,
   input  logic                 k_valid,
   input  logic                 k_border,
   output logic                 k_ready,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [COL_WIDTH-1:0] m_col,
   output logic [ROW_WIDTH-1:0] m_row,
   output logic                 m_sof,
   output logic                 m_eol,
   output logic                 m_eof,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 border_err
);

   // Last valid top-left window position inside a frame.
   localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(IMG_WIDTH - BLOCK_WIDTH);
   localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(IMG_HEIGHT - BLOCK_HEIGHT);

   // Number of windows between the last window of one frame and the first
   // window of the next; all of them mix pixels of two frames.
   localparam int SKIP = (BLOCK_HEIGHT - 1) * IMG_WIDTH + BLOCK_WIDTH - 1;

   // The flush reuses col/row as a raster counter over full image rows.
   // Its final drop lands at (BLOCK_WIDTH-2, BLOCK_HEIGHT-1); with a one-wide
   // kernel there is no partial row, so it ends at the end of the last full row.
   localparam int FL_ROW_I = (BLOCK_WIDTH > 1)  ? BLOCK_HEIGHT - 1 :
                             (BLOCK_HEIGHT > 1) ? BLOCK_HEIGHT - 2 : 0;
   localparam int FL_COL_I = (BLOCK_WIDTH > 1)  ? BLOCK_WIDTH - 2 : IMG_WIDTH - 1;

   localparam logic [COL_WIDTH-1:0] FL_LAST_COL = COL_WIDTH'(FL_COL_I);
   localparam logic [ROW_WIDTH-1:0] FL_LAST_ROW = ROW_WIDTH'(FL_ROW_I);
   localparam logic [COL_WIDTH-1:0] IMG_LAST_COL = COL_WIDTH'(IMG_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   state_t               state_q;
   logic [COL_WIDTH-1:0] col_q;
   logic [ROW_WIDTH-1:0] row_q;
   logic                 start_pend_q;
   logic                 frame_done_q;
   logic                 border_err_q;

   // Next-value helpers for the position counters.
   logic [COL_WIDTH-1:0] col_d;
   logic [ROW_WIDTH-1:0] row_d;

   // Handshake/event decode.
   logic in_stream;
   logic in_flush;
   logic xfer;
   logic border_drop;
   logic flush_drop;
   logic col_at_last;
   logic row_at_last;
   logic flush_at_end;
   logic flush_row_end;

   assign in_stream     = (state_q == ST_STREAM);
   assign in_flush      = (state_q == ST_FLUSH);
   assign xfer          = in_stream & k_valid & ~k_border & m_ready;
   assign border_drop   = in_stream & k_valid & k_border;
   assign flush_drop    = in_flush & k_valid;
   assign col_at_last   = (col_q == LAST_COL);
   assign row_at_last   = (row_q == LAST_ROW);
   assign flush_at_end  = (col_q == FL_LAST_COL) & (row_q == FL_LAST_ROW);
   assign flush_row_end = (col_q == IMG_LAST_COL);

   // Counter advance values: +1 on the column, +1 on the row at a row wrap.
   always_comb begin
      col_d = col_q + COL_WIDTH'(1);
      row_d = row_q + ROW_WIDTH'(1);
   end

   // Kernel-side ready: idle back-pressures, border and flush windows are
   // always swallowed, interior windows pass the downstream ready straight through.
   always_comb begin
      k_ready = 1'b0;
      case (state_q)
         ST_STREAM: k_ready = k_border ? 1'b1 : m_ready;
         ST_FLUSH:  k_ready = 1'b1;
         default:   k_ready = 1'b0;
      endcase
   end

   // Downstream side: only interior windows while streaming; never looks at m_ready.
   assign m_valid = in_stream & k_valid & ~k_border;
   assign m_col   = col_q;
   assign m_row   = row_q;
   assign m_sof   = m_valid & (col_q == '0) & (row_q == '0);
   assign m_eol   = m_valid & col_at_last;
   assign m_eof   = m_valid & col_at_last & row_at_last;

   assign busy       = (state_q != ST_IDLE);
   assign frame_done = frame_done_q;
   assign border_err = border_err_q;

   // Frame sequencer: state, window position, pending start and status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         start_pend_q <= 1'b0;
         frame_done_q <= 1'b0;
         border_err_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;

         // A start while a frame is still running is remembered for later.
         if (start && (state_q != ST_IDLE)) begin
            start_pend_q <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (start || start_pend_q) begin
                  state_q      <= ST_STREAM;
                  start_pend_q <= 1'b0;
                  border_err_q <= 1'b0;
                  col_q        <= '0;
                  row_q        <= '0;
               end
            end

            ST_STREAM: begin
               if (xfer) begin
                  if (col_at_last) begin
                     col_q <= '0;
                     if (row_at_last) begin
                        row_q        <= '0;
                        state_q      <= (SKIP == 0) ? ST_IDLE : ST_FLUSH;
                        frame_done_q <= 1'b1;
                     end else begin
                        row_q <= row_d;
                     end
                  end else begin
                     col_q <= col_d;
                  end
               end
               // A border window is only legitimate right at a row wrap.
               if (border_drop && (col_q != '0)) begin
                  border_err_q <= 1'b1;
               end
            end

            ST_FLUSH: begin
               if (flush_drop) begin
                  if (flush_at_end) begin
                     col_q   <= '0;
                     row_q   <= '0;
                     state_q <= ST_IDLE;
                  end else if (flush_row_end) begin
                     col_q <= '0;
                     row_q <= row_d;
                  end else begin
                     col_q <= col_d;
                  end
               end
            end

            default: begin
               state_q <= ST_IDLE;
               col_q   <= '0;
               row_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lin_buff_ctrl.sv
// Testbench for lin_buff_ctrl on a 6x5 image with a 3x3 kernel.
// Expected behaviour comes from a frame-level model: a transfer count per frame
// (position = count split into column/row), a drop count during the flush,
// plus pending-start and error flags.
module tb_lin_buff_ctrl;

   localparam int W    = 6;
   localparam int H    = 5;
   localparam int BW   = 3;
   localparam int BH   = 3;
   localparam int CW   = 3;
   localparam int RW   = 3;
   localparam int NCOL = W - BW + 1;            // windows per row
   localparam int NROW = H - BH + 1;            // window rows per frame
   localparam int NWIN = NCOL * NROW;           // windows per frame
   localparam int SKIP = (BH - 1) * W + BW - 1; // windows dropped between frames

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          k_valid;
   logic          k_border;
   logic          k_ready;
   logic          m_valid;
   logic          m_ready;
   logic [CW-1:0] m_col;
   logic [RW-1:0] m_row;
   logic          m_sof;
   logic          m_eol;
   logic          m_eof;
   logic          busy;
   logic          frame_done;
   logic          border_err;

   lin_buff_ctrl #(
      .IMG_WIDTH   (W),
      .IMG_HEIGHT  (H),
      .BLOCK_WIDTH (BW),
      .BLOCK_HEIGHT(BH),
      .COL_WIDTH   (CW),
      .ROW_WIDTH   (RW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k_valid   (k_valid),
      .k_border  (k_border),
      .k_ready   (k_ready),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_col     (m_col),
      .m_row     (m_row),
      .m_sof     (m_sof),
      .m_eol     (m_eol),
      .m_eof     (m_eof),
      .busy      (busy),
      .frame_done(frame_done),
      .border_err(border_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Frame-level model: 0 = idle, 1 = streaming a frame, 2 = skipping inter-frame windows.
   int mdl_phase;
   int mdl_n;       // windows transferred in the current frame
   int mdl_drops;   // windows dropped since the frame ended
   bit mdl_pend;
   bit mdl_err;
   bit mdl_fd;
   bit last_consumed;
   bit alt_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mdl_phase = 0;
      mdl_n     = 0;
      mdl_drops = 0;
      mdl_pend  = 1'b0;
      mdl_err   = 1'b0;
      mdl_fd    = 1'b0;
   endtask

   // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
   task automatic cycle(input bit s, input bit kv, input bit kb, input bit mr);
      bit exp_kr;
      bit exp_mv;
      bit fd_next;
      start    = s;
      k_valid  = kv;
      k_border = kb;
      m_ready  = mr;
      if (!rst) model_reset();
      @(negedge clk);
      exp_kr = (mdl_phase == 1) ? (kb ? 1'b1 : mr) : (mdl_phase == 2);
      exp_mv = (mdl_phase == 1) && kv && !kb;
      chk("k_ready", k_ready, exp_kr);
      chk("m_valid", m_valid, exp_mv);
      chk("busy", busy, mdl_phase != 0);
      chk("frame_done", frame_done, mdl_fd);
      chk("border_err", border_err, mdl_err);
      if (exp_mv) begin
         chk("m_col", m_col, mdl_n % NCOL);
         chk("m_row", m_row, mdl_n / NCOL);
         chk("m_sof", m_sof, mdl_n == 0);
         chk("m_eol", m_eol, (mdl_n % NCOL) == NCOL - 1);
         chk("m_eof", m_eof, mdl_n == NWIN - 1);
      end else begin
         chk("m_sof_idle", m_sof, 0);
         chk("m_eof_idle", m_eof, 0);
      end
      last_consumed = kv && exp_kr;
      fd_next = 1'b0;
      if (rst) begin
         case (mdl_phase)
            0: begin
               if (s || mdl_pend) begin
                  mdl_phase = 1;
                  mdl_n     = 0;
                  mdl_pend  = 1'b0;
                  mdl_err   = 1'b0;
               end
            end
            1: begin
               if (s) mdl_pend = 1'b1;
               if (kv && kb) begin
                  if ((mdl_n % NCOL) != 0) mdl_err = 1'b1;
               end else if (kv && mr) begin
                  mdl_n++;
                  if (mdl_n == NWIN) begin
                     mdl_phase = 2;
                     mdl_drops = 0;
                     fd_next   = 1'b1;
                  end
               end
            end
            default: begin
               if (s) mdl_pend = 1'b1;
               if (kv) begin
                  mdl_drops++;
                  if (mdl_drops == SKIP) mdl_phase = 0;
               end
            end
         endcase
      end
      mdl_fd = fd_next;
      @(posedge clk);
      #1;
   endtask

   // Present one window until it is consumed. mode 0: m_ready=1,
   // 1: m_ready alternating, 2: random m_ready with random gaps.
   task automatic send_win(input bit kb, input int mode);
      bit mr;
      last_consumed = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (mode == 2 && $urandom_range(0, 3) == 0) begin
            cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
         end
         if (mode == 0)      mr = 1'b1;
         else if (mode == 1) mr = alt_ready;
         else                mr = 1'($urandom_range(0, 1));
         alt_ready = ~alt_ready;
         cycle(1'b0, 1'b1, kb, mr);
         if (last_consumed) break;
      end
      chk("window_consumed", last_consumed, 1);
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      k_valid   = 1'b0;
      k_border  = 1'b0;
      m_ready   = 1'b0;
      alt_ready = 1'b1;
      model_reset();
      #1;

      // 1: reset held with random inputs, then released without a start
      for (int i = 0; i < 5; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);

      // 2: full frame, m_ready=1, border pairs at the row wraps
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         send_win((i == 4) || (i == 5) || (i == 10) || (i == 11), 0);
      end
      for (int i = 0; i < SKIP; i++) send_win(1'b0, 0);

      // 3: same frame with alternating m_ready
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         send_win((i == 4) || (i == 5) || (i == 10) || (i == 11), 1);
      end

      // 4: start during the flush, then 20 windows straight in
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) send_win(1'b0, 0);

      // 5: border window mid-row (column 2), error sticks until the next start
      chk("pos_before_border", m_col, 2);
      send_win(1'b1, 0);
      for (int i = 0; i < NWIN - 6; i++) send_win(1'b0, 0);
      for (int i = 0; i < SKIP; i++) send_win(1'b0, 0);
      chk("err_held_idle", border_err, 1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);

      // 6: reset mid-frame after the 7th transfer, restart from (0,0)
      for (int i = 0; i < 7; i++) send_win(1'b0, 0);
      rst = 1'b0;
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      send_win(1'b0, 0);

      // Random traffic: random ready/gaps, occasional borders and stray starts
      for (int it = 0; it < 400; it++) begin
         if (mdl_phase == 0) begin
            cycle(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
         end else if ($urandom_range(0, 15) == 0) begin
            cycle(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
         end else begin
            send_win(1'($urandom_range(0, 5) == 0), 2);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
